// File: rtl/dbg_pkg.sv
// Shared definitions for the core debug controller: FSM states, abstract
// register numbers, halt cause codes and the dcsr field layout.
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'd0,
        ST_HALTING  = 2'd1,
        ST_HALTED   = 2'd2,
        ST_RESUMING = 2'd3
    } dbg_state_t;

    localparam logic [15:0] REGNO_GPR_BASE = 16'h1000;
    localparam logic [15:0] REGNO_DCSR     = 16'h07B0;
    localparam logic [15:0] REGNO_DPC      = 16'h07B1;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    localparam logic [3:0] XDEBUGVER = 4'd4;
    localparam logic [1:0] PRV_M     = 2'd3;

    // GPR window is 32 consecutive regnos starting at an aligned base.
    function automatic logic is_gpr(input logic [15:0] regno);
        return regno[15:5] == REGNO_GPR_BASE[15:5];
    endfunction

    // Assemble the architecturally visible dcsr value.
    function automatic logic [31:0] dcsr_pack(input logic [2:0] cause, input logic step);
        return {XDEBUGVER, 19'd0, cause, 3'd0, step, PRV_M};
    endfunction

endpackage

// File: rtl/dbg_ar_port.sv
// Abstract register access port: decodes the regno, drives the register
// file write strobe, raises dcsr/dpc write strobes for the top and holds
// the registered read data returned to the debug module.
module dbg_ar_port
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        ar_wr,
    input  logic [15:0] ar_ad,
    input  logic [31:0] ar_do,
    input  logic [31:0] dcsr_val,
    input  logic [31:0] dpc_val,
    input  logic [31:0] rf_rdata,
    output logic [31:0] ar_di,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        dcsr_we,
    output logic        dpc_we
);

    logic        hit_gpr;
    logic        hit_dcsr;
    logic        hit_dpc;
    logic [31:0] rd_mux;

    assign hit_gpr  = is_gpr(ar_ad);
    assign hit_dcsr = (ar_ad == REGNO_DCSR);
    assign hit_dpc  = (ar_ad == REGNO_DPC);

    // GPR writes go straight through; x0 is left for the register file to drop.
    assign rf_we    = accept && ar_wr && hit_gpr;
    assign rf_addr  = ar_ad[4:0];
    assign rf_wdata = ar_do;
    assign dcsr_we  = accept && ar_wr && hit_dcsr;
    assign dpc_we   = accept && ar_wr && hit_dpc;

    // Read source select; unmapped regnos read as zero.
    always_comb begin
        rd_mux = 32'd0;
        if (hit_gpr)
            rd_mux = rf_rdata;
        else if (hit_dcsr)
            rd_mux = dcsr_val;
        else if (hit_dpc)
            rd_mux = dpc_val;
    end

    // Capture read data on an accepted read and hold it until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ar_di <= 32'd0;
        else if (accept && !ar_wr)
            ar_di <= rd_mux;
    end

endmodule

// File: rtl/core_debug_ctrl.sv
// Core debug controller: run/halt/resume FSM, dpc and dcsr state, and the
// abstract register access path (in dbg_ar_port).
// Optional single-step support is built when DEBUG_STEP_EN is defined.
module core_debug_ctrl
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        core_halt_req,
    input  logic        core_resume_req,
    input  logic        ar_en,
    input  logic        ar_wr,
    input  logic [15:0] ar_ad,
    input  logic [31:0] ar_do,
    output logic [31:0] ar_di,
    output logic        core_halt,
    output logic        core_resume,
    output logic        core_running,
    output logic        pipe_halt,
    input  logic        pipe_idle,
    input  logic [31:0] pc_next,
    input  logic        instr_retire,
    output logic [31:0] resume_pc,
    output logic        resume_pc_load,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

    dbg_state_t  state_reg;
    dbg_state_t  state_next;
    logic [31:0] dpc_reg;
    logic [2:0]  cause_reg;
    logic [2:0]  pend_cause_reg;
    logic        step_reg;
    logic        ar_accept;
    logic        dcsr_we;
    logic        dpc_we;
    logic        step_done;

    // Abstract commands only take effect while the core is fully halted.
    assign ar_accept = ar_en && (state_reg == ST_HALTED);

`ifdef DEBUG_STEP_EN
    logic stepping_reg;
    logic unused_retire;

    assign unused_retire = 1'b0;
    // Single step finishes on the first retirement after resuming.
    assign step_done = stepping_reg && instr_retire;

    // Step enable bit and "currently stepping" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_reg     <= 1'b0;
            stepping_reg <= 1'b0;
        end else begin
            if (dcsr_we)
                step_reg <= ar_do[2];
            if (state_reg == ST_RESUMING)
                stepping_reg <= step_reg;
            else if (state_reg != ST_RUNNING)
                stepping_reg <= 1'b0;
        end
    end
`else
    logic unused_step_sigs;

    assign unused_step_sigs = dcsr_we ^ instr_retire;
    assign step_done        = 1'b0;

    // Step bit is hardwired to zero without step support.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step_reg <= 1'b0;
        else
            step_reg <= 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ST_RUNNING;
        else
            state_reg <= state_next;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next     = state_reg;
        core_running   = 1'b0;
        core_halt      = 1'b0;
        core_resume    = 1'b0;
        resume_pc_load = 1'b0;
        pipe_halt      = 1'b0;
        case (state_reg)
            ST_RUNNING: begin
                core_running = 1'b1;
                if (core_halt_req || step_done)
                    state_next = ST_HALTING;
            end
            ST_HALTING: begin
                pipe_halt = 1'b1;
                if (pipe_idle)
                    state_next = ST_HALTED;
            end
            ST_HALTED: begin
                pipe_halt = 1'b1;
                core_halt = 1'b1;
                // Halt request wins when both are asserted.
                if (core_resume_req && !core_halt_req)
                    state_next = ST_RESUMING;
            end
            ST_RESUMING: begin
                core_resume    = 1'b1;
                resume_pc_load = 1'b1;
                state_next     = ST_RUNNING;
            end
            default: state_next = ST_RUNNING;
        endcase
    end

    // dpc capture on halt, debugger writes, and halt cause bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpc_reg        <= 32'd0;
            cause_reg      <= CAUSE_NONE;
            pend_cause_reg <= CAUSE_NONE;
        end else begin
            // An external halt request outranks a completing step.
            if (state_reg == ST_RUNNING && state_next == ST_HALTING)
                pend_cause_reg <= core_halt_req ? CAUSE_HALTREQ : CAUSE_STEP;
            if (state_reg == ST_HALTING && pipe_idle) begin
                dpc_reg   <= pc_next;
                cause_reg <= pend_cause_reg;
            end else if (dpc_we) begin
                dpc_reg <= ar_do;
            end
        end
    end

    assign resume_pc = dpc_reg;

    dbg_ar_port u_ar_port (
        .clk      (clk),
        .rst      (rst),
        .accept   (ar_accept),
        .ar_wr    (ar_wr),
        .ar_ad    (ar_ad),
        .ar_do    (ar_do),
        .dcsr_val (dcsr_pack(cause_reg, step_reg)),
        .dpc_val  (dpc_reg),
        .rf_rdata (rf_rdata),
        .ar_di    (ar_di),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .dcsr_we  (dcsr_we),
        .dpc_we   (dpc_we)
    );

endmodule
